// File: rtl/hipass_gate_ctrl.sv
// Hi-pass toll-lane sequencer: tag-gated barrier control, lane counter enable, pass tally and alarm.
// Moore outputs decoded from the registered state (1-clk input->output latency); async active-high reset.
module hipass_gate_ctrl #(
  parameter int TAG_TIMEOUT = 6,
  parameter int OPEN_CYC    = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             car_det_i,
  input  logic             tag_valid_i,
  input  logic             tag_ok_i,
  input  logic             car_pass_i,
  input  logic             alarm_ack_i,
  output logic [1:0]       en_o,
  output logic             gate_open_o,
  output logic             alarm_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic             pass_ovf_o,
  output logic [2:0]       state_o
);

  localparam int TMAX = (TAG_TIMEOUT > OPEN_CYC) ? TAG_TIMEOUT : OPEN_CYC;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_TAG = 3'd1,
    S_OPEN     = 3'd2,
    S_CLOSE    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   cnt_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    case (state_q)
      S_IDLE: begin
        if (car_det_i) state_d = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        // A tag strobe on the final waiting cycle takes priority over the timeout.
        if (tag_valid_i)                           state_d = tag_ok_i ? S_OPEN : S_ALARM;
        else if (tmr_q == TW'(TAG_TIMEOUT - 1))    state_d = S_ALARM;
      end
      S_OPEN: begin
        if (car_pass_i) begin
          state_d = S_CLOSE;
          cnt_d   = cnt_inc[CNT_W-1:0];
          if (cnt_inc[CNT_W]) ovf_d = 1'b1;
        end else if (tmr_q == TW'(OPEN_CYC - 1)) begin
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: state_d = S_IDLE;
      S_ALARM: begin
        if (alarm_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);
  end

  always_comb begin
    en_o        = 2'b00;
    gate_open_o = 1'b0;
    alarm_o     = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_OPEN: begin
        en_o        = 2'b10;
        gate_open_o = 1'b1;
      end
      S_CLOSE: en_o    = 2'b01;
      S_ALARM: alarm_o = 1'b1;
      default: ;
    endcase
  end

  assign pass_cnt_o = cnt_q;
  assign pass_ovf_o = ovf_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_hipass_gate_ctrl.sv
// Bench for hipass_gate_ctrl: directed table, corner-case sequences and a randomized run against a lane model.
module tb_hipass_gate_ctrl;
  localparam int TO = 6;
  localparam int OC = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, car_det, tag_valid, tag_ok, car_pass, alarm_ack;
  logic [1:0] en;
  logic gate_open, alarm, busy, pass_ovf;
  logic [CW-1:0] pass_cnt;
  logic [2:0] state;

  hipass_gate_ctrl #(.TAG_TIMEOUT(TO), .OPEN_CYC(OC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .car_det_i(car_det), .tag_valid_i(tag_valid),
    .tag_ok_i(tag_ok), .car_pass_i(car_pass), .alarm_ack_i(alarm_ack),
    .en_o(en), .gate_open_o(gate_open), .alarm_o(alarm), .busy_o(busy),
    .pass_cnt_o(pass_cnt), .pass_ovf_o(pass_ovf), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Lane model: phase plus cycles remaining before that phase times out.
  localparam int P_IDLE = 0, P_WAIT = 1, P_OPEN = 2, P_CLOSE = 3, P_ALARM = 4;
  int m_ph, m_left, m_cnt;
  bit m_ovf;

  task automatic m_reset();
    m_ph = P_IDLE; m_left = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    case (m_ph)
      P_IDLE: if (car_det) begin m_ph = P_WAIT; m_left = TO; end
      P_WAIT: begin
        if (tag_valid) begin
          m_ph = tag_ok ? P_OPEN : P_ALARM;
          m_left = OC;
        end else if (m_left == 1) m_ph = P_ALARM;
        else m_left--;
      end
      P_OPEN: begin
        if (car_pass) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          if (m_cnt == 0) m_ovf = 1;
          m_ph = P_CLOSE;
        end else if (m_left == 1) m_ph = P_CLOSE;
        else m_left--;
      end
      P_CLOSE: m_ph = P_IDLE;
      default: if (alarm_ack) m_ph = P_IDLE;
    endcase
  endtask

  function automatic logic [12:0] m_pack();
    logic [1:0] e;
    e = (m_ph == P_OPEN) ? 2'b10 : (m_ph == P_CLOSE) ? 2'b01 : 2'b00;
    return {3'(m_ph), e, m_ph == P_OPEN, m_ph == P_ALARM, m_ph != P_IDLE, 4'(m_cnt), m_ovf};
  endfunction

  function automatic logic [12:0] dut_pack();
    return {state, en, gate_open, alarm, busy, pass_cnt, pass_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic set_in(input logic cd, input logic tv, input logic tk, input logic cp, input logic ak);
    car_det = cd; tag_valid = tv; tag_ok = tk; car_pass = cp; alarm_ack = ak;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic full_pass();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
  endtask

  typedef struct {
    logic cd, tv, tk, cp, ak;
    logic [2:0] st;
    logic [1:0] en;
    logic gate, alm, bsy;
  } vec_t;

  function automatic vec_t mk(input logic cd, tv, tk, cp, ak,
                              input logic [2:0] st, input logic [1:0] e, input logic g, a, b);
    vec_t v;
    v.cd = cd; v.tv = tv; v.tk = tk; v.cp = cp; v.ak = ak;
    v.st = st; v.en = e; v.gate = g; v.alm = a; v.bsy = b;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    int ncyc;
    tbl[0] = mk(1, 0, 0, 0, 0, 3'd1, 2'b00, 0, 0, 1);
    tbl[1] = mk(0, 0, 0, 0, 0, 3'd1, 2'b00, 0, 0, 1);
    tbl[2] = mk(0, 0, 0, 1, 1, 3'd1, 2'b00, 0, 0, 1);
    tbl[3] = mk(0, 1, 1, 0, 0, 3'd2, 2'b10, 1, 0, 1);
    tbl[4] = mk(0, 0, 0, 0, 0, 3'd2, 2'b10, 1, 0, 1);
    tbl[5] = mk(1, 1, 0, 0, 0, 3'd2, 2'b10, 1, 0, 1);
    tbl[6] = mk(0, 0, 0, 1, 0, 3'd3, 2'b01, 0, 0, 1);
    tbl[7] = mk(1, 0, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0);
    tbl[8] = mk(0, 0, 0, 0, 0, 3'd0, 2'b00, 0, 0, 0);

    // Reset is visible without any clock edge.
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    m_reset();
    #1;
    chk("reset_outputs", {29'd0, dut_pack()}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal pass, table driven.
    foreach (tbl[i]) begin
      set_in(tbl[i].cd, tbl[i].tv, tbl[i].tk, tbl[i].cp, tbl[i].ak);
      tick();
      chk($sformatf("tbl%0d", i), {state, en, gate_open, alarm, busy},
          {tbl[i].st, tbl[i].en, tbl[i].gate, tbl[i].alm, tbl[i].bsy});
    end
    chk("tbl_pass_cnt", pass_cnt, 1);

    // Missing tag: ALARM after exactly TO waiting cycles, held until ack.
    do_reset();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    repeat (TO - 1) tick();
    chk("wait_before_timeout", state, 1);
    tick();
    chk("timeout_alarm", {state, alarm, en}, {3'd4, 1'b1, 2'b00});
    for (int i = 0; i < 5; i++) begin
      set_in(i[0], 1, i[1], 1, 0);
      tick();
    end
    chk("alarm_holds", {state, alarm, gate_open, pass_cnt}, {3'd4, 1'b1, 1'b0, 4'd0});
    set_in(0, 0, 0, 0, 1); tick();
    chk("alarm_ack", {state, alarm, busy}, {3'd0, 1'b0, 1'b0});

    // Bad tag, then good tag on the last waiting cycle.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 0); tick();
    chk("bad_tag_alarm", {state, alarm}, {3'd4, 1'b1});
    set_in(0, 0, 0, 0, 1); tick();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    repeat (TO - 1) tick();
    set_in(0, 1, 1, 0, 0); tick();
    chk("tag_beats_timeout", {state, gate_open, en}, {3'd2, 1'b1, 2'b10});

    // Open timeout: count-enable held for exactly OC cycles, then one clear cycle.
    set_in(0, 0, 0, 0, 0);
    ncyc = 1;
    for (int i = 0; i < 3 * OC; i++) begin
      tick();
      if (en != 2'b10) break;
      ncyc++;
    end
    chk("open_cycles", ncyc, OC);
    chk("open_timeout_close", {state, en, gate_open, pass_cnt}, {3'd3, 2'b01, 1'b0, 4'd0});
    tick();
    chk("close_to_idle", state, 0);

    // Tally wrap and sticky overflow.
    do_reset();
    repeat (16) full_pass();
    chk("wrap_16", {pass_cnt, pass_ovf}, {4'd0, 1'b1});
    full_pass();
    chk("wrap_17", {pass_cnt, pass_ovf}, {4'd1, 1'b1});

    // Asynchronous reset in the middle of OPEN, then a stray car_pass in IDLE.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    chk("open_before_rst", gate_open, 1);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst_open", {state, en, gate_open, pass_cnt, pass_ovf}, {3'd0, 2'b00, 1'b0, 4'd0, 1'b0});
    #1;
    rst = 1'b0;
    full_pass();
    set_in(0, 0, 0, 1, 0); tick();
    chk("idle_car_pass_ignored", {state, pass_cnt}, {3'd0, 4'd1});

    // Randomized traffic against the lane model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      tick();
      chk($sformatf("rand%0d", i), {19'd0, dut_pack()}, {19'd0, m_pack()});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
